// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between the IO block's transmit-data register and the buffered UART.
// The master offers bytes and the UART (slave) signals when it can take one.
interface uart_tx_buffered_if;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_in_ready;

   modport master (output data_in, output data_in_valid, input data_in_ready);
   modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a serialiser FSM.
// A new frame is popped on the last stop-bit cycle, so queued frames run back to back.
module uart_tx_buffered #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   uart_tx_buffered_if.slave             host,
   output logic                          serial_out,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int S  = CLOCK_FREQ / BAUD_RATE;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = (S > 1) ? $clog2(S) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_reg;
   logic [CW-1:0] cycle_reg;
   logic [2:0]    bit_reg;
   logic [8:0]    shift_reg;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;

   logic push;
   logic pop;
   logic bit_end;
   logic fifo_nonempty;

   assign fifo_nonempty      = (count_reg != '0);
   assign host.data_in_ready = (count_reg != (AW+1)'(FIFO_DEPTH));
   assign push               = host.data_in_valid && host.data_in_ready;
   assign bit_end            = (cycle_reg == CW'(S - 1));
   assign pop                = fifo_nonempty && ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));

   assign tx_busy    = (state_reg != IDLE) || fifo_nonempty;
   assign fifo_count = count_reg;

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr_reg] <= host.data_in;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // shift_reg holds the bits still to send after the start bit: {stop, data[7:0]}.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         cycle_reg  <= '0;
         bit_reg    <= '0;
         shift_reg  <= '1;
         serial_out <= 1'b1;
      end else if (pop) begin
         shift_reg  <= {1'b1, mem[rd_ptr_reg]};
         serial_out <= 1'b0;
         cycle_reg  <= '0;
         bit_reg    <= '0;
         state_reg  <= START;
      end else begin
         case (state_reg)
            IDLE: begin
               serial_out <= 1'b1;
            end
            START: begin
               if (bit_end) begin
                  cycle_reg  <= '0;
                  serial_out <= shift_reg[0];
                  shift_reg  <= {1'b1, shift_reg[8:1]};
                  bit_reg    <= '0;
                  state_reg  <= DATA;
               end else begin
                  cycle_reg <= cycle_reg + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cycle_reg  <= '0;
                  serial_out <= shift_reg[0];
                  shift_reg  <= {1'b1, shift_reg[8:1]};
                  bit_reg    <= bit_reg + 1'b1;
                  if (bit_reg == 3'd7) begin
                     state_reg <= STOP;
                  end
               end else begin
                  cycle_reg <= cycle_reg + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cycle_reg  <= '0;
                  serial_out <= 1'b1;
                  state_reg  <= IDLE;
               end else begin
                  cycle_reg <= cycle_reg + 1'b1;
               end
            end
            default: begin
               state_reg  <= IDLE;
               serial_out <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered at S=10: frame-level reference model, line receiver,
// a table of push vectors and directed sequences for the timing corner cases.
module tb_uart_tx_buffered;
   localparam int S     = 10;
   localparam int FW    = 10 * S;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       serial_out;
   logic       tx_busy;
   logic [2:0] fifo_count;

   uart_tx_buffered_if bus ();

   uart_tx_buffered #(
      .CLOCK_FREQ(1000),
      .BAUD_RATE (100),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .host      (bus.slave),
      .serial_out(serial_out),
      .tx_busy   (tx_busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Frame-level reference: a byte queue plus the time elapsed in the current frame.
   logic [7:0] m_q[$];
   logic [7:0] tx_log[$];
   logic [7:0] m_cur;
   bit         m_active;
   int         m_t;

   // Independent line receiver sampling mid-bit.
   bit         rx_active;
   int         rx_cnt;
   logic [7:0] rx_byte;
   logic [7:0] rx_q[$];
   int         rx_start[$];

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic [2:0] exp_count;
      logic       exp_ready;
   } vec_t;

   vec_t t2[6];
   int   t1_exp[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic exp_line();
      int idx;
      if (!m_active) return 1'b1;
      idx = m_t / S;
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return m_cur[idx-1];
   endfunction

   task automatic model_step(input bit rst, input bit v, input logic [7:0] d);
      bit acc;
      if (rst) begin
         if (m_active && m_t < 9*S + S/2) void'(tx_log.pop_back());
         m_q.delete();
         m_active = 0;
         m_t = 0;
         return;
      end
      acc = v && (m_q.size() != DEPTH);
      if ((!m_active || m_t == FW-1) && m_q.size() != 0) begin
         m_cur = m_q.pop_front();
         tx_log.push_back(m_cur);
         m_active = 1;
         m_t = 0;
      end else if (m_active && m_t == FW-1) begin
         m_active = 0;
      end else if (m_active) begin
         m_t++;
      end
      if (acc) m_q.push_back(d);
   endtask

   task automatic rx_step(input bit rst);
      int idx;
      if (rst) begin
         rx_active = 0;
         return;
      end
      if (!rx_active) begin
         if (serial_out === 1'b0) begin
            rx_active = 1;
            rx_cnt = 0;
            rx_start.push_back(cyc);
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % S == S/2) begin
            idx = rx_cnt / S;
            if (idx == 0) check("rx_start_bit", 32'(serial_out), 32'd0);
            else if (idx <= 8) rx_byte[idx-1] = serial_out;
            else begin
               check("rx_stop_bit", 32'(serial_out), 32'd1);
               rx_q.push_back(rx_byte);
               rx_active = 0;
            end
         end
      end
   endtask

   task automatic tick();
      bit r;
      logic [2:0] ecount;
      r = reset;
      model_step(r, bus.data_in_valid, bus.data_in);
      @(posedge clk);
      #1;
      cyc++;
      ecount = 3'(m_q.size());
      check("cycle_outputs",
            {26'd0, serial_out, tx_busy, bus.data_in_ready, fifo_count},
            {26'd0, exp_line(), (m_active || m_q.size() != 0), (m_q.size() != DEPTH), ecount});
      rx_step(r);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_idle();
      int budget = 20 * FW;
      while ((m_active || m_q.size() != 0 || rx_active) && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) check("drain_timeout", 32'd0, 32'd1);
      ticks(2);
   endtask

   task automatic compare_rx(input string name);
      check({name, "_count"}, 32'(rx_q.size()), 32'(tx_log.size()));
      for (int i = 0; i < tx_log.size() && i < rx_q.size(); i++)
         check({name, "_byte"}, 32'(rx_q[i]), 32'(tx_log[i]));
      rx_q.delete();
      tx_log.delete();
      rx_start.delete();
   endtask

   initial begin
      bus.data_in_valid = 1'b0;
      bus.data_in = 8'h00;
      t1_exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      t2[0] = '{1'b1, 8'h01, 3'd1, 1'b1};
      t2[1] = '{1'b1, 8'h02, 3'd1, 1'b1};
      t2[2] = '{1'b1, 8'h03, 3'd2, 1'b1};
      t2[3] = '{1'b1, 8'h04, 3'd3, 1'b1};
      t2[4] = '{1'b1, 8'h05, 3'd4, 1'b0};
      t2[5] = '{1'b1, 8'h06, 3'd4, 1'b0};

      // Reset state
      reset = 1'b1;
      ticks(2);
      check("reset_serial", 32'(serial_out), 32'd1);
      check("reset_count", 32'(fifo_count), 32'd0);
      check("reset_busy", 32'(tx_busy), 32'd0);
      check("reset_ready", 32'(bus.data_in_ready), 32'd1);
      reset = 1'b0;
      ticks(3);

      // T1: single 0xA5 frame, sampled once per bit from the pop edge
      bus.data_in_valid = 1'b1;
      bus.data_in = 8'hA5;
      tick();
      bus.data_in_valid = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         check("t1_frame_bit", 32'(serial_out), 32'(t1_exp[i]));
         ticks(10);
      end
      check("t1_idle_line", 32'(serial_out), 32'd1);
      check("t1_idle_busy", 32'(tx_busy), 32'd0);
      wait_idle();
      compare_rx("t1_rx");

      // T2: held valid into an idle FSM, table-driven
      for (int i = 0; i < 6; i++) begin
         bus.data_in_valid = t2[i].valid;
         bus.data_in = t2[i].data;
         tick();
         check("t2_count", 32'(fifo_count), 32'(t2[i].exp_count));
         check("t2_ready", 32'(bus.data_in_ready), 32'(t2[i].exp_ready));
      end
      bus.data_in_valid = 1'b0;
      wait_idle();
      check("t2_rx_count", 32'(rx_q.size()), 32'd5);
      for (int i = 0; i < 5 && i < rx_q.size(); i++)
         check("t2_rx_byte", 32'(rx_q[i]), 32'(i + 1));
      compare_rx("t2_rx");

      // T3: back-to-back frames with zero gap
      bus.data_in_valid = 1'b1;
      bus.data_in = 8'h00;
      tick();
      bus.data_in = 8'hFF;
      tick();
      bus.data_in_valid = 1'b0;
      wait_idle();
      check("t3_starts", 32'(rx_start.size()), 32'd2);
      if (rx_start.size() == 2)
         check("t3_frame_spacing", 32'(rx_start[1] - rx_start[0]), 32'(FW));
      compare_rx("t3_rx");

      // T4: valid on the STOP pop edge with the FIFO full
      bus.data_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.data_in = 8'h10 + 8'(i);
         tick();
      end
      bus.data_in_valid = 1'b0;
      for (int b = 0; b < 2*FW && !(m_active && m_t == FW-1); b++) tick();
      check("t4_full_count", 32'(fifo_count), 32'd4);
      check("t4_full_ready", 32'(bus.data_in_ready), 32'd0);
      bus.data_in_valid = 1'b1;
      bus.data_in = 8'h5A;
      tick();
      check("t4_pop_edge_count", 32'(fifo_count), 32'd3);
      tick();
      check("t4_next_edge_count", 32'(fifo_count), 32'd4);
      bus.data_in_valid = 1'b0;
      wait_idle();
      check("t4_rx_total", 32'(rx_q.size()), 32'd6);
      compare_rx("t4_rx");

      // T5: reset mid-DATA with three bytes queued
      bus.data_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.data_in = 8'h31 + 8'(i);
         tick();
      end
      bus.data_in_valid = 1'b0;
      check("t5_queued", 32'(fifo_count), 32'd3);
      ticks(3 * S);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_serial", 32'(serial_out), 32'd1);
      check("t5_count", 32'(fifo_count), 32'd0);
      check("t5_busy", 32'(tx_busy), 32'd0);
      check("t5_ready", 32'(bus.data_in_ready), 32'd1);
      ticks(12 * S);
      check("t5_no_residual", 32'(rx_q.size()), 32'd0);
      compare_rx("t5_rx");

      // T6: randomized fill/drain bursts, pointers wrap many times
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 6; i++) begin
            bus.data_in_valid = ($urandom_range(0, 4) != 0);
            bus.data_in = 8'($urandom);
            tick();
         end
         bus.data_in_valid = 1'b0;
         ticks($urandom_range(0, 3 * FW));
      end
      wait_idle();
      check("t6_min_bytes", 32'(tx_log.size() >= 12), 32'd1);
      compare_rx("t6_rx");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
